// File: rtl/nanorv32_dbg_console.sv
// Debug console AHB-Lite slave: character FIFO, test-result latch and cycle counter.
// The character FIFO is drained by a ready/valid consumer; line_flush marks a popped newline.
module nanorv32_dbg_console #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] PASS_CODE  = 32'hCAFFE000,
    parameter logic [31:0] FAIL_CODE  = 32'hDEAD0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic [31:0] hrdata,
    output logic        hresp,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        line_flush,
    output logic        test_done,
    output logic [1:0]  test_status
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_TXDATA     = 2'd0,
        REG_STATUS     = 2'd1,
        REG_TESTRESULT = 2'd2,
        REG_CYCLES     = 2'd3
    } reg_sel_e;

    logic          dp_valid_q, dp_valid_d;
    logic          dp_write_q, dp_write_d;
    reg_sel_e      dp_sel_q, dp_sel_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [31:0]   cycles_q, cycles_d;
    logic          test_done_q, test_done_d;
    logic [1:0]    test_status_q, test_status_d;
    logic          line_flush_q, line_flush_d;

    logic          empty, full, tx_wr, push, pop;
    logic [8:0]    level;
    logic          unused_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = 9'(wr_ptr_q - rd_ptr_q);

    // A full FIFO holds the write in its data phase; only state at the start of the cycle counts.
    assign tx_wr = dp_valid_q && dp_write_q && (dp_sel_q == REG_TXDATA);
    assign push  = tx_wr && !full;
    assign pop   = char_valid && char_ready;

    assign hreadyout   = !(tx_wr && full);
    assign hresp       = 1'b0;
    assign char_valid  = !empty;
    assign char_data   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign line_flush  = line_flush_q;
    assign test_done   = test_done_q;
    assign test_status = test_status_q;
    assign unused_ok   = ^{haddr[31:4], haddr[1:0], htrans[0], hsize, level[8]};

    always_comb begin
        dp_valid_d    = dp_valid_q;
        dp_write_d    = dp_write_q;
        dp_sel_d      = dp_sel_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cycles_d      = cycles_q + 32'd1;
        test_done_d   = test_done_q;
        test_status_d = test_status_q;
        line_flush_d  = pop && (char_data == 8'h0A);

        if (hready) begin
            dp_valid_d = hsel && htrans[1];
            dp_write_d = hwrite;
            dp_sel_d   = reg_sel_e'(haddr[3:2]);
        end
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        if (dp_valid_q && dp_write_q && (dp_sel_q == REG_TESTRESULT) && !test_done_q) begin
            test_done_d = 1'b1;
            if (hwdata == PASS_CODE)      test_status_d = 2'd1;
            else if (hwdata == FAIL_CODE) test_status_d = 2'd2;
            else                          test_status_d = 2'd3;
        end
    end

    always_comb begin
        hrdata = 32'h0;
        if (dp_valid_q && !dp_write_q) begin
            case (dp_sel_q)
                REG_STATUS:     hrdata = {16'h0, level[7:0], 6'b0, full, empty};
                REG_TESTRESULT: hrdata = {30'h0, test_status_q};
                REG_CYCLES:     hrdata = cycles_q;
                default:        hrdata = 32'h0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_valid_q    <= 1'b0;
            dp_write_q    <= 1'b0;
            dp_sel_q      <= REG_TXDATA;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cycles_q      <= 32'h0;
            test_done_q   <= 1'b0;
            test_status_q <= 2'd0;
            line_flush_q  <= 1'b0;
        end else begin
            dp_valid_q    <= dp_valid_d;
            dp_write_q    <= dp_write_d;
            dp_sel_q      <= dp_sel_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cycles_q      <= cycles_d;
            test_done_q   <= test_done_d;
            test_status_q <= test_status_d;
            line_flush_q  <= line_flush_d;
        end
    end

    // NOTE: storage is not reset; the pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= hwdata[7:0];
    end

endmodule
